// File: rtl/int_to_fp.sv
// int_to_fp: converts a 16-bit two's-complement integer into the 14-bit
// sign / 4-bit exponent / 9-bit normalized fraction FP format (value = 0.frac * 2^exp).
// Latency: out_valid rises s+1 cycles after the accepting edge (s = number of left shifts, 0..15).
// Backpressure: in_ready only in IDLE; results are held stable in DONE until out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_data (16b signed) sampled on the accepting edge
//   out_valid/out_ready   output handshake for sign, exp[3:0], frac[8:0], ovf
//
// Build option: define INT_TO_FP_ROUND_EN to round half-up on the first bit below the
// 9-bit fraction window; otherwise the fraction is truncated.

module int_to_fp (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [3:0]  exp,
    output logic [8:0]  frac,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        neg;        // sign of the accepted integer
    logic [15:0] mag;        // magnitude being normalized
    logic [4:0]  e;          // exponent counter, starts at 16

    logic        norm_done;
    logic [3:0]  res_exp;
    logic [8:0]  res_frac;
    logic        res_ovf;

`ifdef INT_TO_FP_ROUND_EN
    logic [9:0]  frac_rnd;
    logic [4:0]  exp_rnd;
`endif

    // Normalization stops once the leading one sits at bit 15, or immediately for zero.
    assign norm_done = (mag == 16'd0) || mag[15];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = NORM;
            NORM: if (norm_done) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- Result formatting (evaluated on the NORM->DONE edge) ----------------
    always_comb begin
        res_exp  = e[3:0];
        res_frac = mag[15:7];
        res_ovf  = 1'b0;
`ifdef INT_TO_FP_ROUND_EN
        // Half-up on mag[6]; a carry out of the fraction renormalizes to 0x100 with exp+1.
        frac_rnd = {1'b0, mag[15:7]} + {9'd0, mag[6]};
        exp_rnd  = e + {4'd0, frac_rnd[9]};
        if (exp_rnd[4]) begin
            // Exponent of 16 or more cannot be encoded: saturate.
            res_exp  = 4'd15;
            res_frac = 9'h1FF;
            res_ovf  = 1'b1;
        end else if (frac_rnd[9]) begin
            res_exp  = exp_rnd[3:0];
            res_frac = 9'h100;
        end else begin
            res_frac = frac_rnd[8:0];
        end
`else
        // e stays at 16 only for -32768 (magnitude 0x8000), which the 4-bit exponent cannot hold.
        if (e[4]) begin
            res_exp  = 4'd15;
            res_frac = 9'h1FF;
            res_ovf  = 1'b1;
        end
`endif
        if (mag == 16'd0) begin
            res_exp  = 4'd0;
            res_frac = 9'd0;
            res_ovf  = 1'b0;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg  <= 1'b0;
            mag  <= 16'd0;
            e    <= 5'd0;
            sign <= 1'b0;
            exp  <= 4'd0;
            frac <= 9'd0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg <= in_data[15];
                        // Negation of 0x8000 wraps back to 0x8000, the correct unsigned magnitude.
                        mag <= in_data[15] ? (~in_data + 16'd1) : in_data;
                        e   <= 5'd16;
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        sign <= neg && (mag != 16'd0);
                        exp  <= res_exp;
                        frac <= res_frac;
                        ovf  <= res_ovf;
                    end else begin
                        mag <= {mag[14:0], 1'b0};
                        e   <= e - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/int_to_fp.md
# int_to_fp

Sequential converter from 16-bit two's-complement integers to the 14-bit sign/exponent/fraction floating-point format used by the FP datapath (sign, 4-bit exponent, 9-bit normalized fraction).
- It is the producing end for the FP comparator and other FP consumers.
- It accepts one integer per valid/ready transaction and normalizes it by shifting one bit per cycle.
- It returns the FP fields through a valid/ready output handshake.

## Interface
- No parameters; widths are fixed by the FP format.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a new integer.
- in_data  input  16  signed two's-complement integer.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- sign  output  1  1 = negative.
- exp  output  4  exponent.
- frac  output  9  normalized fraction; frac[8]=1 unless the value is zero.
- ovf  output  1  magnitude exceeded the format and the result was saturated.

## Operation
- Encoded value = 0.frac × 2^exp.
  - For a magnitude m whose most-significant 1 is at bit p: exp = p+1, frac = m bits [p:p-8], zero-filled below bit 0.
  - Fraction bits below the 9-bit window are truncated.
- States:
  - IDLE: in_ready=1. On in_valid:
    - load sign = in_data[15].
    - load mag = |in_data| (16 bits unsigned; -32768 yields 0x8000).
    - set e = 16 (5-bit counter).
    - go to NORM.
  - NORM: if mag==0 or mag[15]==1, go to DONE. Otherwise shift mag left by 1, decrement e, and stay in NORM.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- Output field values in DONE:
  - Zero: sign=0, exp=0, frac=0, ovf=0. A negative sign is never produced for zero.
  - e==16 (only for in_data=-32768): saturate to exp=15, frac=0x1FF, ovf=1; sign is kept.
  - Otherwise: exp=e[3:0], frac=mag[15:7], ovf=0.
- sign/exp/frac/ovf are registered on entry to DONE and held stable while out_valid=1 and out_ready=0.
- in_ready=1 only in IDLE. There is no overlap between an output transfer and a new acceptance.

## Timing
- Reset value of all outputs:
  - in_ready=1 once reset deasserts (state IDLE).
  - out_valid=0, sign=0, exp=0, frac=0, ovf=0.
- Reset asserted mid-conversion aborts immediately to IDLE; the partial result is discarded and no out_valid is produced.
- Latency: out_valid rises s+1 cycles after the accepting clock edge, where s = 15-p is the number of left shifts.
  - in_data=0: 1 cycle.
  - |in_data| ≥ 0x8000: 1 cycle.
  - |in_data|=1: 16 cycles (maximum).
- Output transfer occurs on the edge where out_valid && out_ready. in_ready rises the following cycle.
- Minimum spacing between acceptances: latency + 2 cycles when out_ready is tied high.
- in_data is sampled only on the accepting edge; changes during NORM/DONE are ignored.

## Configuration
- INT_TO_FP_ROUND_EN defined: round half-up on the first bit below the window (mag[6] in DONE-entry evaluation).
  - Rounding is computed combinationally on the DONE transition, so latency is unchanged.
  - If frac would carry out of 0x1FF: frac=0x100 and exp=e+1.
  - If the rounded exponent reaches 16: saturate to exp=15, frac=0x1FF, ovf=1.
- INT_TO_FP_ROUND_EN undefined: pure truncation, as described in Operation.

## Test plan
- in_data=5, out_ready=1 → out_valid 14 cycles after accept; sign=0, exp=3, frac=0x140, ovf=0.
- in_data=0 → out_valid after 1 cycle; sign=0, exp=0, frac=0, ovf=0.
- in_data=-1 → sign=1, exp=1, frac=0x100, out_valid after 16 cycles.
- in_data=-32768 → sign=1, exp=15, frac=0x1FF, ovf=1 after 1 cycle.
- in_data=1023 → 0/10/0x1FF without ROUND_EN; 0/11/0x100 with ROUND_EN.
- in_data=32767 → 0/15/0x1FF/ovf=0 without ROUND_EN; ovf=1 saturated with ROUND_EN.
- Backpressure: hold out_ready=0 for 10 cycles → outputs stable, in_ready=0 throughout.
- Reset pulse during NORM → out_valid=0 and in_ready=1 after release; the next conversion is correct.
